seq_producer: RTL and testbench

Write-side source for the inter-clock buffer. Generates either the Fibonacci sequence or a free-running timer count on the fast clock domain, and presents one 16-bit value at a time on data_1/data_1_en. Honours buffer_full backpressure so no value is ever offered while the buffer is full and none is silently lost. Sits between the user controls (start/stop/mode) and the buffer's write port.

---
 rtl/seq_producer.sv | 197 +++++++++++++++++++
 tb/tb_seq_producer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seq_producer.sv
// seq_producer: write-side source for the inter-clock buffer.
// Generates the Fibonacci sequence (mode=0) or a wrapping timer count
// (mode=1) and offers one 16-bit value at a time to the buffer write port,
// honouring buffer_full so no value is offered while full or silently lost.
//
// Optional build macro: FIB_WRAP_EN -- when defined, Fibonacci restarts at 0
// after 46368 instead of stopping in DONE.
//
// Ports:
//   clk         fast clock (buffer write-side clock)
//   rst         asynchronous active-high reset
//   start       one-cycle pulse, begins generation (from IDLE or DONE)
//   stop        one-cycle pulse, aborts generation (wins over start)
//   mode        0 = Fibonacci, 1 = timer; sampled on accepted start
//   buffer_full 1 = buffer cannot accept a write
//   data_1_en   combinational write strobe, value written on this clk edge
//   data_1      registered value offered to the buffer
//   busy        1 while generating (RUN)
//   done        1 once Fibonacci is exhausted (DONE)
//   overrun     sticky: a timer tick replaced a value that was never written
module seq_producer #(
  parameter int unsigned TICK_DIV  = 10,
  parameter int unsigned TIMER_MAX = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        mode,
  input  logic        buffer_full,
  output logic        data_1_en,
  output logic [15:0] data_1,
  output logic        busy,
  output logic        done,
  output logic        overrun
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 16;
  localparam int unsigned FW = DW + 1;

  localparam logic [DW-1:0] FIB_LAST  = DW'(46368);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] TMAX      = DW'(TIMER_MAX);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] data_1_q, data_1_d;
  logic          pending_q, pending_d;
  logic [PW-1:0] prescaler_q, prescaler_d;
  logic [DW-1:0] a_q, a_d;
  logic [FW-1:0] b_q, b_d;
  logic          mode_q, mode_d;
  logic          overrun_q, overrun_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          write_c;
  logic          tick_c;

  // Write strobe is combinational so a full flag raised by the previous
  // write blocks the very next offer.
  assign write_c = (state_q == ST_RUN) && pending_q && !buffer_full;
  assign tick_c  = (prescaler_q == TICK_LAST);

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    data_1_d    = data_1_q;
    pending_d   = pending_q;
    prescaler_d = prescaler_q;
    a_d         = a_q;
    b_d         = b_q;
    mode_d      = mode_q;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          a_d         = '0;
          b_d         = FW'(1);
          data_1_d    = '0;
          prescaler_d = '0;
          overrun_d   = 1'b0;
          pending_d   = 1'b1;
        end
      end

      ST_RUN: begin
        if (stop) begin
          state_d     = ST_IDLE;
          pending_d   = 1'b0;
          prescaler_d = '0;
        end else if (!mode_q) begin
          // Fibonacci: always pending, advance only on an accepted write
          if (write_c) begin
            if (data_1_q == FIB_LAST) begin
`ifdef FIB_WRAP_EN
              a_d       = '0;
              b_d       = FW'(1);
              data_1_d  = '0;
              pending_d = 1'b1;
`else
              // Next term (75025) no longer fits 16 bits
              state_d   = ST_DONE;
              pending_d = 1'b0;
`endif
            end else begin
              data_1_d = b_q[DW-1:0];
              a_d      = b_q[DW-1:0];
              b_d      = FW'(a_q) + b_q;
            end
          end
        end else begin
          // Timer: prescaler runs regardless of backpressure
          prescaler_d = tick_c ? '0 : prescaler_q + PW'(1);
          if (tick_c) begin
            data_1_d  = (data_1_q == TMAX) ? '0 : data_1_q + DW'(1);
            pending_d = 1'b1;
            // Newest count replaces one that was never written
            if (pending_q && !write_c) begin
              overrun_d = 1'b1;
            end
          end else if (write_c) begin
            pending_d = 1'b0;
          end
        end
      end

      ST_DONE: begin
        if (stop) begin
          state_d     = ST_IDLE;
          pending_d   = 1'b0;
          prescaler_d = '0;
        end else if (start) begin
          state_d     = ST_RUN;
          mode_d      = mode;
          a_d         = '0;
          b_d         = FW'(1);
          data_1_d    = '0;
          prescaler_d = '0;
          overrun_d   = 1'b0;
          pending_d   = 1'b1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
      end
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      data_1_q    <= '0;
      pending_q   <= 1'b0;
      prescaler_q <= '0;
      a_q         <= '0;
      b_q         <= FW'(1);
      mode_q      <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_1_q    <= data_1_d;
      pending_q   <= pending_d;
      prescaler_q <= prescaler_d;
      a_q         <= a_d;
      b_q         <= b_d;
      mode_q      <= mode_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign data_1_en = write_c;
  assign data_1    = data_1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seq_producer.sv
// Directed bench for seq_producer (TICK_DIV=4, TIMER_MAX=5).
// Inputs change right after the falling edge; outputs are checked 1 time
// unit later, well before the next rising edge.
module tb_seq_producer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic        mode;
  logic        buffer_full;
  logic        data_1_en;
  logic [15:0] data_1;
  logic        busy;
  logic        done;
  logic        overrun;

  int total = 0;
  int bad   = 0;

  int unsigned fa, fb, ft;

  always #5 clk = ~clk;

  seq_producer #(
    .TICK_DIV  (4),
    .TIMER_MAX (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .buffer_full (buffer_full),
    .data_1_en   (data_1_en),
    .data_1      (data_1),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; buffer_full = 1'b0;
    nx(); nx();
    #1;
    chk("rst_en",      32'(data_1_en), 0);
    chk("rst_data",    32'(data_1),    0);
    chk("rst_busy",    32'(busy),      0);
    chk("rst_done",    32'(done),      0);
    chk("rst_overrun", 32'(overrun),   0);
    nx(); rst = 1'b0;

    // Fibonacci, no backpressure: 25 back-to-back writes
    nx(); start = 1'b1; mode = 1'b0;
    #1 chk("idle_en", 32'(data_1_en), 0);
    nx(); start = 1'b0;
    fa = 0; fb = 1;
    for (int i = 0; i < 25; i++) begin
      #1;
      chk("fib_en",   32'(data_1_en), 1);
      chk("fib_data", 32'(data_1),    fa);
      ft = fa + fb; fa = fb; fb = ft;
      nx();
    end
    #1;
`ifdef FIB_WRAP_EN
    fa = 0; fb = 1;
    for (int i = 0; i < 4; i++) begin
      chk("wrap_en",   32'(data_1_en), 1);
      chk("wrap_data", 32'(data_1),    fa);
      chk("wrap_done", 32'(done),      0);
      ft = fa + fb; fa = fb; fb = ft;
      nx(); #1;
    end
    ft = fa;
`else
    chk("fib_end_done", 32'(done),      1);
    chk("fib_end_busy", 32'(busy),      0);
    chk("fib_end_en",   32'(data_1_en), 0);
    chk("fib_end_data", 32'(data_1),    46368);
    ft = 46368;
`endif
    stop = 1'b1;
    nx(); stop = 1'b0;
    #1;
    chk("stop_busy", 32'(busy),      0);
    chk("stop_done", 32'(done),      0);
    chk("stop_en",   32'(data_1_en), 0);
    chk("stop_data", 32'(data_1),    ft);

    // Fibonacci with buffer_full during cycles 3..7
    nx(); start = 1'b1; mode = 1'b0;
    nx(); start = 1'b0;
    fa = 0; fb = 1;
    for (int k = 0; k < 13; k++) begin
      buffer_full = (k >= 3 && k <= 7);
      #1;
      chk("bp_en",   32'(data_1_en), 32'(!buffer_full));
      chk("bp_data", 32'(data_1),    fa);
      if (!buffer_full) begin
        ft = fa + fb; fa = fb; fb = ft;
      end
      nx();
    end
    buffer_full = 1'b0; stop = 1'b1;
    nx(); stop = 1'b0;

    // Timer: writes every 4 cycles, wrap after 5
    nx(); start = 1'b1; mode = 1'b1;
    nx(); start = 1'b0; mode = 1'b0;
    for (int k = 0; k < 26; k++) begin
      #1;
      chk("tmr_en",   32'(data_1_en), 32'(k % 4 == 0));
      chk("tmr_data", 32'(data_1),    32'((k / 4) % 6));
      nx();
    end
    #1;
    chk("tmr_overrun", 32'(overrun), 0);
    chk("tmr_busy",    32'(busy),    1);
    stop = 1'b1;
    nx(); stop = 1'b0;

    // Timer with buffer_full across two ticks
    nx(); start = 1'b1; mode = 1'b1; buffer_full = 1'b1;
    nx(); start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      buffer_full = (k < 8);
      #1;
      chk("ovr_en",      32'(data_1_en), 32'(k == 8));
      chk("ovr_data",    32'(data_1),    32'(k / 4));
      chk("ovr_overrun", 32'(overrun),   32'(k >= 4));
      nx();
    end

    // stop and start together: stop wins, overrun kept
    stop = 1'b1; start = 1'b1;
    nx(); stop = 1'b0; start = 1'b0;
    #1;
    chk("ss_busy",    32'(busy),      0);
    chk("ss_en",      32'(data_1_en), 0);
    chk("ss_overrun", 32'(overrun),   1);
    chk("ss_data",    32'(data_1),    2);

    // A new start clears overrun
    nx(); start = 1'b1; mode = 1'b1;
    nx(); start = 1'b0;
    #1;
    chk("rs_overrun", 32'(overrun),   0);
    chk("rs_en",      32'(data_1_en), 1);
    chk("rs_data",    32'(data_1),    0);
    stop = 1'b1;
    nx(); stop = 1'b0;

    // Async reset in the middle of a Fibonacci write
    nx(); start = 1'b1; mode = 1'b0;
    nx(); start = 1'b0;
    nx(); nx(); nx(); nx();
    #1;
    chk("pre_rst_en",   32'(data_1_en), 1);
    chk("pre_rst_data", 32'(data_1),    3);
    rst = 1'b1;
    #1;
    chk("arst_en",   32'(data_1_en), 0);
    chk("arst_data", 32'(data_1),    0);
    chk("arst_busy", 32'(busy),      0);
    chk("arst_done", 32'(done),      0);
    nx(); rst = 1'b0;
    nx(); #1;
    chk("post_rst_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
